// File: rtl/flit_tx_ctrl.sv
// Output-side packet transmitter: pops head..tail from the input FIFO after
// switch allocation and streams flits downstream under a req/grant handshake.
module flit_tx_ctrl #(
  parameter int FW        = 40,
  parameter int MAX_FLITS = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FW-1:0]    fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             sa_req,
  input  logic             sa_grant,
  output logic [FW-1:0]    flit_out,
  output logic             req_out,
  input  logic             grant_in,
  output logic             port_release,
  output logic [CNT_W-1:0] flit_cnt,
  output logic             proto_err,
  output logic             len_err
);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    XFER,
    DRAIN
  } state_t;

  localparam logic [1:0] T_HEAD = 2'b11;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b01;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       typ;
  logic [CNT_W-1:0] pop_cnt;
  logic             can_pop;
  logic             xfer;
  logic             load;
  logic             perr_nxt;
  logic             lerr_nxt;
  logic             rel_nxt;

  assign typ     = fifo_dout[FW-1:FW-2];
  assign sa_req  = (state != IDLE);
  assign xfer    = req_out & grant_in;
  // A new flit may enter flit_out only if the slot is free or leaving now.
  assign can_pop = !fifo_empty && (!req_out || grant_in);

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    load      = 1'b0;
    perr_nxt  = 1'b0;
    rel_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (typ == T_HEAD) begin
            state_nxt = ARB;
          end else begin
            fifo_rd  = 1'b1;
            perr_nxt = 1'b1;
          end
        end
      end
      ARB: begin
        if (sa_grant) state_nxt = XFER;
      end
      XFER: begin
        if (can_pop) begin
          unique case (typ)
            T_HEAD: begin
              // A second head closes the packet without a tail.
              if (pop_cnt == '0) begin
                fifo_rd = 1'b1;
                load    = 1'b1;
              end else begin
                perr_nxt  = 1'b1;
                state_nxt = DRAIN;
              end
            end
            T_BODY: begin
              fifo_rd = 1'b1;
              load    = 1'b1;
            end
            T_TAIL: begin
              fifo_rd   = 1'b1;
              load      = 1'b1;
              state_nxt = DRAIN;
            end
            default: begin
              fifo_rd  = 1'b1;
              perr_nxt = 1'b1;
            end
          endcase
        end
      end
      DRAIN: begin
        if (!req_out || grant_in) begin
          rel_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    lerr_nxt = load && (pop_cnt == CNT_W'(MAX_FLITS - 1))
               && (typ != T_TAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      flit_out     <= '0;
      req_out      <= 1'b0;
      port_release <= 1'b0;
      flit_cnt     <= '0;
      pop_cnt      <= '0;
      proto_err    <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      port_release <= rel_nxt;
      proto_err    <= perr_nxt;
      len_err      <= lerr_nxt;
      if (load) begin
        flit_out <= fifo_dout;
        req_out  <= 1'b1;
      end else if (xfer) begin
        req_out  <= 1'b0;
      end
      if (state == IDLE) begin
        flit_cnt <= '0;
      end else if (xfer && (flit_cnt != '1)) begin
        flit_cnt <= flit_cnt + 1'b1;
      end
      if (state == IDLE) begin
        pop_cnt <= '0;
      end else if (load && (pop_cnt != '1)) begin
        pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flit_tx_ctrl.sv
// Directed bench for flit_tx_ctrl: cycle table for the basic packet and
// discard cases, FIFO-queue sequences for stalls, aborts, length, reset.
module tb_flit_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        sa_req;
  logic        sa_grant;
  logic [39:0] flit_out;
  logic        req_out;
  logic        grant_in;
  logic        port_release;
  logic [3:0]  flit_cnt;
  logic        proto_err;
  logic        len_err;

  flit_tx_ctrl #(.FW(40), .MAX_FLITS(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .sa_req(sa_req), .sa_grant(sa_grant),
    .flit_out(flit_out), .req_out(req_out), .grant_in(grant_in),
    .port_release(port_release), .flit_cnt(flit_cnt),
    .proto_err(proto_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] typ;
    logic [7:0] tag;
    logic       empty;
    logic       sag;
    logic       gin;
    logic       e_rd;
    logic       e_sareq;
    logic       e_req;
    logic [1:0] e_typ;
    logic [7:0] e_tag;
    logic       e_rel;
    logic [3:0] e_cnt;
    logic       e_perr;
    logic       e_lerr;
  } vec_t;

  vec_t        tbl[12];
  logic [39:0] q[$];
  logic [39:0] rx[$];
  logic [39:0] ex[$];
  int checks = 0;
  int errors = 0;
  int perr_n, lerr_n, rel_n, rx_at_rel, stall_bad, stall_cyc;
  logic        hold_prev;
  logic [39:0] prev_flit;

  function automatic logic [39:0] mk(input logic [1:0] t,
                                     input logic [7:0] g);
    return {t, 30'b0, g};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    rx.delete();
    ex.delete();
    perr_n    = 0;
    lerr_n    = 0;
    rel_n     = 0;
    rx_at_rel = -1;
    stall_bad = 0;
    stall_cyc = 0;
    hold_prev = 1'b0;
    prev_flit = '0;
  endtask

  // One clock of the queue-backed FIFO; called at a negedge.
  task automatic cyc();
    logic rd_s;
    fifo_empty = (q.size() == 0);
    fifo_dout  = fifo_empty ? 40'b0 : q[0];
    #1;
    rd_s = fifo_rd;
    if (req_out && grant_in) rx.push_back(flit_out);
    if (req_out && !grant_in) begin
      stall_cyc++;
      if (fifo_rd) stall_bad++;
    end
    if (hold_prev && (!req_out || flit_out !== prev_flit)) stall_bad++;
    hold_prev = req_out && !grant_in;
    prev_flit = flit_out;
    if (proto_err) perr_n++;
    if (len_err) lerr_n++;
    if (port_release) begin
      if (rel_n == 0) rx_at_rel = rx.size();
      rel_n++;
    end
    @(posedge clk);
    if (rd_s) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input string nm, input int budget,
                     input int stall_at, input int stall_len);
    int stalled = 0;
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      grant_in = !(rx.size() == stall_at && stalled < stall_len);
      if (!grant_in) stalled++;
      cyc();
      done = (q.size() == 0) && !sa_req && !req_out;
    end
    grant_in = 1'b1;
    cyc();
    cyc();
    chk({nm, " done"}, {63'b0, done}, 64'd1);
  endtask

  task automatic chk_rx(input string nm);
    chk({nm, " rx_len"}, rx.size(), ex.size());
    for (int i = 0; i < ex.size(); i++) begin
      if (i < rx.size()) chk($sformatf("%s flit%0d", nm, i), rx[i], ex[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    //          typ   tag  emp sag gin rd  sr  rq  etyp etag rel cnt pe  le
    tbl[0]  = '{2'b11, 8'h01, 0, 0, 1, 0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0};
    tbl[1]  = '{2'b11, 8'h01, 0, 1, 1, 0, 1, 0, 2'b00, 8'h00, 0, 0, 0, 0};
    tbl[2]  = '{2'b11, 8'h01, 0, 0, 1, 1, 1, 0, 2'b00, 8'h00, 0, 0, 0, 0};
    tbl[3]  = '{2'b10, 8'h02, 0, 0, 1, 1, 1, 1, 2'b11, 8'h01, 0, 0, 0, 0};
    tbl[4]  = '{2'b10, 8'h03, 0, 0, 1, 1, 1, 1, 2'b10, 8'h02, 0, 1, 0, 0};
    tbl[5]  = '{2'b01, 8'h04, 0, 0, 1, 1, 1, 1, 2'b10, 8'h03, 0, 2, 0, 0};
    tbl[6]  = '{2'b00, 8'h00, 1, 0, 1, 0, 1, 1, 2'b01, 8'h04, 0, 3, 0, 0};
    tbl[7]  = '{2'b00, 8'h00, 1, 0, 1, 0, 0, 0, 2'b00, 8'h00, 1, 4, 0, 0};
    tbl[8]  = '{2'b00, 8'h00, 1, 0, 1, 0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0};
    tbl[9]  = '{2'b10, 8'h09, 0, 0, 1, 1, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0};
    tbl[10] = '{2'b00, 8'h00, 1, 0, 1, 0, 0, 0, 2'b00, 8'h00, 0, 0, 1, 0};
    tbl[11] = '{2'b00, 8'h00, 1, 0, 1, 0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0};

    rst_n      = 1'b0;
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    sa_grant   = 1'b0;
    grant_in   = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    #1;
    chk("rst req_out", req_out, 0);
    chk("rst flit_out", flit_out, 0);
    chk("rst flit_cnt", flit_cnt, 0);
    chk("rst release", port_release, 0);
    chk("rst errs", {proto_err, len_err}, 0);
    chk("rst comb", {fifo_rd, sa_req}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      fifo_dout  = mk(tbl[i].typ, tbl[i].tag);
      fifo_empty = tbl[i].empty;
      sa_grant   = tbl[i].sag;
      grant_in   = tbl[i].gin;
      #1;
      chk($sformatf("v%0d fifo_rd", i), fifo_rd, tbl[i].e_rd);
      chk($sformatf("v%0d sa_req", i), sa_req, tbl[i].e_sareq);
      chk($sformatf("v%0d req_out", i), req_out, tbl[i].e_req);
      if (tbl[i].e_req)
        chk($sformatf("v%0d flit_out", i), flit_out,
            mk(tbl[i].e_typ, tbl[i].e_tag));
      chk($sformatf("v%0d release", i), port_release, tbl[i].e_rel);
      chk($sformatf("v%0d flit_cnt", i), flit_cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d proto_err", i), proto_err, tbl[i].e_perr);
      chk($sformatf("v%0d len_err", i), len_err, tbl[i].e_lerr);
      @(negedge clk);
    end

    sa_grant = 1'b1;

    clr();
    q  = '{mk(2'b11, 8'h21), mk(2'b10, 8'h22), mk(2'b10, 8'h23),
           mk(2'b01, 8'h24)};
    ex = q;
    run("stall", 60, 2, 3);
    chk_rx("stall");
    chk("stall cycles", stall_cyc, 3);
    chk("stall hold", stall_bad, 0);
    chk("stall release", rel_n, 1);
    chk("stall perr", perr_n, 0);

    clr();
    q  = '{mk(2'b11, 8'h41), mk(2'b10, 8'h42), mk(2'b11, 8'h43),
           mk(2'b10, 8'h44), mk(2'b01, 8'h45)};
    ex = q;
    run("abort", 80, -1, 0);
    chk_rx("abort");
    chk("abort rx_at_rel", rx_at_rel, 2);
    chk("abort perr", perr_n, 1);
    chk("abort release", rel_n, 2);

    clr();
    q  = '{mk(2'b11, 8'h51), mk(2'b10, 8'h52), mk(2'b10, 8'h53),
           mk(2'b10, 8'h54), mk(2'b01, 8'h55)};
    ex = q;
    run("len", 60, -1, 0);
    chk_rx("len");
    chk("len lerr", lerr_n, 1);
    chk("len release", rel_n, 1);
    chk("len perr", perr_n, 0);

    clr();
    q = '{mk(2'b11, 8'h61), mk(2'b10, 8'h62), mk(2'b10, 8'h63),
          mk(2'b01, 8'h64)};
    grant_in = 1'b0;
    for (int i = 0; i < 20 && !req_out; i++) cyc();
    chk("mid req_out", req_out, 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst req_out", req_out, 0);
    chk("mid rst sa_req", sa_req, 0);
    chk("mid rst flit_out", flit_out, 0);
    chk("mid rst flit_cnt", flit_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    clr();
    q  = '{mk(2'b11, 8'h71), mk(2'b10, 8'h72), mk(2'b01, 8'h73)};
    ex = q;
    run("restart", 60, -1, 0);
    chk_rx("restart");
    chk("restart release", rel_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
